// File: rtl/sprite_ctrl.sv
// sprite_ctrl: fills the sprite bitmap with a generated pattern, then bounces the sprite once per frame tick.
module sprite_ctrl #(
  parameter int VGA_WIDTH        = 640,
  parameter int VGA_HEIGHT       = 480,
  parameter int SPRITE_SIZE_BITS = 6,
  parameter int SCALE_DIV_BITS   = 8,
  parameter int SCALE_MIN        = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         pattern_sel,
  input  logic [7:0]         cfg_vx,
  input  logic [7:0]         cfg_vy,
  input  logic [3:0]         cfg_scale,
  input  logic               frame_tick,
  output logic               busy,
  output logic               running,
  output logic [31:0]        bitmap_address,
  output logic [7:0]         bitmap_din,
  output logic               bitmap_we,
  output logic signed [31:0] x,
  output logic signed [31:0] y,
  output logic [31:0]        scale,
  output logic [15:0]        frame_count
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_next;
  logic [12:0] cnt, cnt_next;
  logic [1:0] pat, pat_next;
  logic signed [8:0] vx, vy, vx_next, vy_next;
  logic busy_next, running_next, we_next;
  logic [31:0] addr_next, scale_next;
  logic [7:0] din_next, pat_data;
  logic signed [31:0] x_next, y_next, nx, ny, size, xmax, ymax;
  logic [15:0] fc_next;
  logic [5:0] ax, ay;
  logic [3:0] clamped;
  assign ax = cnt[5:0];
  assign ay = cnt[11:6];
  assign pat_data = pat == 2'd0 ? 8'hFF :
                    pat == 2'd1 ? {8{ax[3] ^ ay[3]}} :
                    pat == 2'd2 ? {ay[5:2], ax[5:2]} :
                    {8{~|ax | &ax | ~|ay | &ay}};
  assign clamped = cfg_scale < 4'(SCALE_MIN) ? 4'(SCALE_MIN) :
                   cfg_scale > 4'(SCALE_DIV_BITS) ? 4'(SCALE_DIV_BITS) : cfg_scale;
  assign size = 32'(1 << SPRITE_SIZE_BITS) << (32'(SCALE_DIV_BITS) - scale);
  assign xmax = 32'(VGA_WIDTH) - size;
  assign ymax = 32'(VGA_HEIGHT) - size;
  assign nx = x + {{23{vx[8]}}, vx};
  assign ny = y + {{23{vy[8]}}, vy};
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pat_next     = pat;
    vx_next      = vx;
    vy_next      = vy;
    busy_next    = busy;
    running_next = running;
    we_next      = bitmap_we;
    addr_next    = bitmap_address;
    din_next     = bitmap_din;
    scale_next   = scale;
    x_next       = x;
    y_next       = y;
    fc_next      = frame_count;
    if (start && state != FILL) begin
      state_next   = FILL;
      busy_next    = 1'b1;
      running_next = 1'b0;
      we_next      = 1'b0;
      pat_next     = pattern_sel;
      vx_next      = {cfg_vx[7], cfg_vx};
      vy_next      = {cfg_vy[7], cfg_vy};
      scale_next   = {28'd0, clamped};
      x_next       = '0;
      y_next       = '0;
      fc_next      = '0;
      cnt_next     = '0;
    end else if (state == FILL) begin
      // cnt[12] marks that address 4095 has already been written
      if (cnt[12]) begin
        state_next   = RUN;
        busy_next    = 1'b0;
        running_next = 1'b1;
        we_next      = 1'b0;
      end else begin
        we_next   = 1'b1;
        addr_next = {20'd0, cnt[11:0]};
        din_next  = pat_data;
        cnt_next  = cnt + 13'd1;
      end
    end else if (state == RUN && frame_tick) begin
      x_next  = nx < 0 ? '0 : nx > xmax ? xmax : nx;
      vx_next = (nx < 0 || nx > xmax) ? -vx : vx;
      y_next  = ny < 0 ? '0 : ny > ymax ? ymax : ny;
      vy_next = (ny < 0 || ny > ymax) ? -vy : vy;
      fc_next = frame_count + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      pat            <= '0;
      vx             <= '0;
      vy             <= '0;
      busy           <= 1'b0;
      running        <= 1'b0;
      bitmap_we      <= 1'b0;
      bitmap_address <= '0;
      bitmap_din     <= '0;
      scale          <= 32'(SCALE_DIV_BITS);
      x              <= '0;
      y              <= '0;
      frame_count    <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      pat            <= pat_next;
      vx             <= vx_next;
      vy             <= vy_next;
      busy           <= busy_next;
      running        <= running_next;
      bitmap_we      <= we_next;
      bitmap_address <= addr_next;
      bitmap_din     <= din_next;
      scale          <= scale_next;
      x              <= x_next;
      y              <= y_next;
      frame_count    <= fc_next;
    end
  end
endmodule

// File: tb/tb_sprite_ctrl.sv
// tb_sprite_ctrl: randomized and directed checks of sprite_ctrl against a behavioural model.
module tb_sprite_ctrl;
  logic clk = 1'b0, reset, start, frame_tick, busy, running, bitmap_we;
  logic [1:0] pattern_sel;
  logic [7:0] cfg_vx, cfg_vy, bitmap_din;
  logic [3:0] cfg_scale;
  logic [31:0] bitmap_address, scale;
  logic signed [31:0] x, y;
  logic [15:0] frame_count;
  int errors = 0, checks = 0;
  int mx, my, mvx, mvy, msc, mfc;
  logic [7:0] mem [4096];

  sprite_ctrl dut (.clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel),
    .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .cfg_scale(cfg_scale), .frame_tick(frame_tick),
    .busy(busy), .running(running), .bitmap_address(bitmap_address), .bitmap_din(bitmap_din),
    .bitmap_we(bitmap_we), .x(x), .y(y), .scale(scale), .frame_count(frame_count));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat_val(input int p, input int a);
    int ax = a % 64, ay = a / 64;
    if (p == 0) return 8'hFF;
    if (p == 1) return ((ax / 8) % 2 != (ay / 8) % 2) ? 8'hFF : 8'h00;
    if (p == 2) return 8'((ay / 4) * 16 + ax / 4);
    return (ax == 0 || ax == 63 || ay == 0 || ay == 63) ? 8'hFF : 8'h00;
  endfunction

  function automatic int bounce(input int pos, inout int v, input int lim);
    int n = pos + v;
    if (n < 0) begin v = -v; return 0; end
    if (n > lim) begin v = -v; return lim; end
    return n;
  endfunction

  task automatic fill(input int p, input int vx, input int vy, input int sc,
                      input bit mid_start, input bit mid_tick, input bit tick_with_start);
    int n = 0, bad = 0;
    for (int a = 0; a < 4096; a++) mem[a] = 'x;
    pattern_sel = 2'(p); cfg_vx = vx[7:0]; cfg_vy = vy[7:0]; cfg_scale = 4'(sc);
    start = 1'b1; frame_tick = tick_with_start;
    step;
    start = 1'b0; frame_tick = 1'b0;
    mvx = vx; mvy = vy; mx = 0; my = 0; mfc = 0;
    msc = sc < 6 ? 6 : sc > 8 ? 8 : sc;
    check("start_busy", busy, 1);
    check("start_running", running, 0);
    check("start_scale", scale, msc);
    check("start_x", x, 0);
    check("start_y", y, 0);
    check("start_fc", frame_count, 0);
    for (int c = 0; c < 4200 && !running; c++) begin
      if (c == 100 && mid_start) begin
        pattern_sel = ~pattern_sel; cfg_vx = ~cfg_vx; cfg_scale = 4'd2; start = 1'b1;
      end
      if (c == 200 && mid_tick) frame_tick = 1'b1;
      step;
      start = 1'b0; frame_tick = 1'b0;
      if (bitmap_we) begin
        if (bitmap_address !== 32'(n)) bad++;
        else if (n < 4096) mem[n] = bitmap_din;
        n++;
      end
    end
    check("fill_writes", n, 4096);
    check("fill_order", bad, 0);
    bad = 0;
    for (int a = 0; a < 4096; a++) if (mem[a] !== pat_val(p, a)) bad++;
    check("fill_data", bad, 0);
    check("fill_busy", busy, 0);
    check("fill_running", running, 1);
    check("fill_we", bitmap_we, 0);
    check("fill_x", x, 0);
    check("fill_y", y, 0);
    check("fill_scale", scale, msc);
  endtask

  task automatic ticks(input int k, input int gap_max);
    for (int i = 0; i < k; i++) begin
      repeat ($urandom_range(0, gap_max)) step;
      check("hold_x", x, mx);
      frame_tick = 1'b1;
      step;
      frame_tick = 1'b0;
      mx = bounce(mx, mvx, 640 - (64 << (8 - msc)));
      my = bounce(my, mvy, 480 - (64 << (8 - msc)));
      mfc = (mfc + 1) % 65536;
      check("tick_x", x, mx);
      check("tick_y", y, my);
      check("tick_fc", frame_count, mfc);
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    pattern_sel = '0; cfg_vx = '0; cfg_vy = '0; cfg_scale = '0;
    repeat (3) step;
    check("rst_busy", busy, 0);
    check("rst_running", running, 0);
    check("rst_we", bitmap_we, 0);
    check("rst_addr", bitmap_address, 0);
    check("rst_din", bitmap_din, 0);
    check("rst_scale", scale, 8);
    check("rst_fc", frame_count, 0);
    reset = 1'b0;
    frame_tick = 1'b1;
    step;
    frame_tick = 1'b0;
    check("idle_tick_fc", frame_count, 0);
    check("idle_tick_x", x, 0);

    fill(0, 10, 0, 8, 0, 0, 0);
    ticks(57, 2);
    check("dir_x57", x, 570);
    ticks(1, 0);
    check("dir_x58", x, 576);
    ticks(1, 0);
    check("dir_x59", x, 566);
    check("dir_y59", y, 0);
    check("dir_fc59", frame_count, 59);

    fill(1, 5, -128, 6, 1, 1, 0);
    check("p1_a8", mem[8], 8'hFF);
    check("p1_a0", mem[0], 8'h00);
    check("p1_a520", mem[520], 8'h00);
    ticks(1, 0);
    check("vy_t1", y, 0);
    ticks(1, 0);
    check("vy_t2", y, 128);
    ticks(1, 0);
    check("vy_t3", y, 224);
    ticks(4, 1);

    fill(3, 3, 3, 2, 0, 0, 0);
    check("p3_a65", mem[65], 8'h00);
    check("p3_a63", mem[63], 8'hFF);
    check("clamp_lo", scale, 6);
    ticks(30, 3);

    fill(2, -7, 9, 12, 0, 0, 1);
    check("clamp_hi", scale, 8);
    ticks(25, 3);

    repeat (2) begin
      fill($urandom_range(0, 3), int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, $urandom_range(0, 15), 0, 0, 0);
      ticks(40, 3);
    end

    pattern_sel = 2'd2; cfg_scale = 4'd6; start = 1'b1;
    step;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      step;
      found = bitmap_we && bitmap_address == 32'd2000;
    end
    check("mid_reset_reach", found, 1);
    reset = 1'b1;
    step;
    check("mrst_we", bitmap_we, 0);
    check("mrst_busy", busy, 0);
    check("mrst_running", running, 0);
    check("mrst_addr", bitmap_address, 0);
    check("mrst_din", bitmap_din, 0);
    check("mrst_scale", scale, 8);
    check("mrst_x", x, 0);
    check("mrst_fc", frame_count, 0);
    reset = 1'b0;
    repeat (3) step;
    check("mrst_idle_we", bitmap_we, 0);
    check("mrst_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sprite_ctrl.md
Name: sprite_ctrl

Overview:
Single-clock sequencer that drives a sprite engine's control inputs from the system clock domain.
- On command, it fills the sprite bitmap RAM through its write port with a selected generated pattern.
- It then animates the sprite once per frame tick: it adds velocity to x/y and bounces off the screen edges.
- It outputs x, y, scale, bitmap_address, bitmap_din and bitmap_we directly to the sprite engine.
- Clock-domain crossing to the video clock is done downstream; this block never crosses domains.

Parameters:
VGA_WIDTH, 640, screen width in pixels
VGA_HEIGHT, 480, screen height in pixels
SPRITE_SIZE_BITS, 6, log2 of bitmap edge (64x64 bitmap, 4096 bytes)
SCALE_DIV_BITS, 8, scale value giving 1:1 display
SCALE_MIN, 6, lowest accepted scale (largest displayed sprite)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: latch config, begin bitmap fill
pattern_sel  in  2  fill pattern, sampled on start
cfg_vx  in  8  signed x velocity, pixels/frame, sampled on start
cfg_vy  in  8  signed y velocity, pixels/frame, sampled on start
cfg_scale  in  4  requested scale, sampled on start
frame_tick  in  1  one-cycle pulse per video frame, already synchronous to clk
busy  out  1  high while filling
running  out  1  high in RUN state
bitmap_address  out  32  bitmap write address, 0..4095
bitmap_din  out  8  bitmap write data
bitmap_we  out  1  bitmap write enable
x  out  32  signed sprite left edge
y  out  32  signed sprite top edge
scale  out  32  scale shift, zero-extended
frame_count  out  16  frames animated since last start; wraps

Behaviour:
- Reset values:
  - State is IDLE.
  - busy, running, bitmap_we, bitmap_address, bitmap_din, x, y and frame_count are 0.
  - scale is SCALE_DIV_BITS (8).
  - Internal velocities are 0.
- Reset asserted mid-FILL or mid-RUN takes effect at the next edge. bitmap_we is low from that edge onward, and no further RAM write occurs.
- States are IDLE, FILL and RUN, and all outputs are registered.
- start in IDLE or RUN:
  - Next state is FILL, with busy=1 and running=0.
  - Latch the pattern and the 9-bit sign-extended velocities.
  - Latch scale = clamp(cfg_scale, SCALE_MIN, SCALE_DIV_BITS).
  - Set x=0, y=0, frame_count=0 and the fill counter to 0.
- start while in FILL is ignored.
- FILL:
  - Each cycle, bitmap_we=1, bitmap_address=counter, bitmap_din=pattern(counter), then counter increments.
  - Exactly 4096 consecutive write cycles for addresses 0..4095 in order.
  - After the write to 4095, the next edge gives bitmap_we=0, busy=0 and state RUN.
  - frame_tick is ignored in FILL.
- Pattern bit fields: ax = address[5:0] and ay = address[11:6].
  - 0: 8'hFF solid.
  - 1: 8'hFF when ax[3]^ay[3], else 8'h00 (8x8 checker).
  - 2: {ay[5:2], ax[5:2]} (gradient).
  - 3: 8'hFF when ax or ay is 0 or 63, else 8'h00 (border).
- Displayed size: S = (1<<SPRITE_SIZE_BITS) << (SCALE_DIV_BITS - scale), giving 64, 128 or 256 for scale 8, 7 or 6.
- Limits: XMAX = VGA_WIDTH-S and YMAX = VGA_HEIGHT-S.
- RUN, on frame_tick: compute nx = x+vx using signed 32-bit arithmetic, and apply per axis, independently, taking effect at the next edge:
  - nx<0: x=0, vx=-vx.
  - nx>XMAX: x=XMAX, vx=-vx.
  - otherwise x=nx.
  - y uses YMAX in the same way.
- frame_count increments on each RUN frame_tick and wraps 65535→0.
- Latency: x, y and frame_count change on the first edge after the sampled frame_tick.
- Without frame_tick, x, y and frame_count are held.
- Velocity 9-bit width makes -(-128)=+128 exact.
- vx=0 holds x indefinitely.
- frame_tick coincident with start: start wins and the tick is dropped.
- IDLE: outputs hold reset values until start.

Test Plan:
- Reset, then start with pattern_sel=0 → busy=1 next cycle; bitmap_we high exactly 4096 cycles, addresses 0..4095 in order, all data 8'hFF; then busy=0 and running=1.
- Fill with pattern_sel=1 → addr 8 (ax=8, ay=0) data FF; addr 0 data 00; addr 520 (ax=8, ay=8) data 00. pattern_sel=3 → addr 65 data 00, addr 63 data FF.
- start cfg_vx=10, cfg_vy=0, cfg_scale=8, then 57 ticks → x=570. Tick 58 → x=576 with vx=-10. Tick 59 → x=566. y stays 0 and frame_count=59.
- cfg_scale=6, cfg_vy=-128 → first tick y=0 and vy becomes +128; next tick y=128; next y=224 (clamped to YMAX) and vy=-128. cfg_scale=2 yields scale=6; cfg_scale=12 yields scale=8.
- Edge cases: start pulsed mid-FILL → ignored, total writes still 4096. frame_tick during FILL → x/y unchanged. frame_tick and start in the same cycle in RUN → FILL entered with x=0 and frame_count=0.
- Reset asserted at fill address 2000 → bitmap_we=0 next edge, state IDLE, all outputs at reset values, scale=8.
